count_sched: RTL and testbench
==============================

COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the counter (2..8).
REQ-002 SHALL have parameter W, default 4: counter and length width.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req, input, NREQ: per-requester level request for a count job.
REQ-006 SHALL have port len, input, NREQ*W: per-requester job length, slice i = len[i*W +: W].
REQ-007 SHALL have port tick, input, 1: count-enable strobe, one count per cycle when high.
REQ-008 SHALL have port gnt, output, NREQ: one-hot grant of the counter, registered.
REQ-009 SHALL have port done, output, NREQ: one-cycle completion pulse to the owning requester, registered.
REQ-010 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.
REQ-011 SHALL have port count_out, output, W: current counter value.

Function
REQ-012 SHALL implement FSM states IDLE, COUNT, DONE.
REQ-013 IDLE: with any req bit high at an edge, SHALL select winner by round-robin starting at index (last+1) mod NREQ, set gnt one-hot, latch len[winner], clear counter to 0, enter COUNT.
REQ-014 SHALL make gnt visible the cycle after the winning req is sampled (one-cycle grant latency).
REQ-015 COUNT: counter SHALL increment by 1 modulo 2^W on each edge with tick=1 and hold otherwise.
REQ-016 COUNT: when tick=1 and count_out == latched_len-1 (mod 2^W), SHALL enter DONE.
REQ-017 latched_len=0 SHALL mean 2^W ticks (counter wraps through full range before DONE).
REQ-018 DONE: SHALL pulse done[winner] for exactly one cycle, clear gnt, set last=winner, return to IDLE.
REQ-019 A new grant SHALL NOT be issued in the DONE cycle; minimum gap between grants is one IDLE cycle.
REQ-020 If req[winner] falls during COUNT, SHALL abort: return to IDLE next edge, clear gnt, no done pulse, set last=winner.
REQ-021 Abort SHALL take priority over terminal-count completion in the same cycle.
REQ-022 len and req changes of non-granted requesters during COUNT SHALL have no effect.
REQ-023 gnt SHALL never have more than one bit set; done SHALL only be set for the bit granted in the preceding cycle.
REQ-024 count_out SHALL hold its final value in DONE and IDLE until the next grant clears it.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, gnt=0, done=0, busy=0, count_out=0, last=NREQ-1, overriding tick and req.
REQ-026 Reset asserted mid-COUNT SHALL drop the job without a done pulse.

Structure
REQ-027 FSM state encoding and the default widths SHALL live in shared package count_pkg.
REQ-028 The counter SHALL be one sub-module, ctr_sync (W-bit up counter, sync active-high clear, active-high enable); the arbiter/FSM stays in count_sched.

Verification
REQ-029 Single job: req[0]=1, len0=3, tick always 1 -> gnt=0001 next cycle, count_out 0,1,2, done[0] one cycle, busy low after.
REQ-030 Round-robin: req=1111 held, all len=1 -> grants in order 0,1,2,3,0 with one IDLE cycle between each.
REQ-031 Sparse tick: req[2]=1, len2=2, tick high every third cycle -> done[2] after second tick only, count_out holds between ticks.
REQ-032 Wrap: len1=0 -> exactly 16 ticks, count_out passes 15->0, done[1] on 16th tick.
REQ-033 Abort: req[3] dropped at count_out=1, len3=5 -> IDLE next cycle, done stays 0, next grant starts from requester 0.
REQ-034 Reset mid-COUNT at count_out=2 -> all outputs 0 next cycle, no done; following req[0] grants requester 0.

Source files
------------

// File: rtl/count_pkg.sv
// Shared FSM encoding and default geometry for the count scheduler.
package count_pkg;

   localparam int unsigned NREQ_DEF = 4;
   localparam int unsigned W_DEF    = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_COUNT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/ctr_sync.sv
// W-bit up counter with synchronous clear (priority) and count enable.
module ctr_sync #(
   parameter int unsigned W = 4
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/count_sched.sv
// Round-robin scheduler granting one shared up counter to NREQ requesters;
// each grant counts len ticks, then pulses done to the owner.
module count_sched
   import count_pkg::*;
#(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned W    = W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] len,
   input  logic              tick,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [W-1:0]      count_out
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            busy_q, busy_d;
   logic [IW-1:0]   win_q, win_d;
   logic [IW-1:0]   last_q, last_d;
   logic [W-1:0]    len_q, len_d;

   logic            found_c;
   logic [IW-1:0]   pick_c;
   logic            ctr_clr_c;
   logic            ctr_en_c;
   logic [W-1:0]    count_c;

   // Round-robin search starting just after the last served requester.
   always_comb begin
      int unsigned idx;
      found_c = 1'b0;
      pick_c  = '0;
      idx     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(last_q) + 32'd1 + k) % NREQ;
         if (!found_c && req[idx]) begin
            found_c = 1'b1;
            pick_c  = IW'(idx);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      done_d    = '0;
      win_d     = win_q;
      last_d    = last_q;
      len_d     = len_q;
      ctr_clr_c = 1'b0;
      ctr_en_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (found_c) begin
               state_d   = ST_COUNT;
               gnt_d     = NREQ'(1) << pick_c;
               win_d     = pick_c;
               len_d     = len[32'(pick_c)*W +: W];
               ctr_clr_c = 1'b1;
            end
         end
         ST_COUNT: begin
            // Owner withdrawing its request wins over a same-cycle terminal count.
            if (!req[win_q]) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               last_d  = win_q;
            end else if (tick) begin
               ctr_en_c = 1'b1;
               if (count_c == W'(len_q - W'(1))) begin
                  state_d = ST_DONE;
                  gnt_d   = '0;
                  done_d  = gnt_q;
                  last_d  = win_q;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         win_q   <= '0;
         last_q  <= IW'(NREQ - 1);
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         win_q   <= win_d;
         last_q  <= last_d;
         len_q   <= len_d;
      end
   end

   ctr_sync #(.W(W)) u_ctr (
      .clock (clock),
      .clear (reset | ctr_clr_c),
      .en    (ctr_en_c),
      .count (count_c)
   );

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign count_out = count_c;

endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched: single job, round-robin, sparse tick, wrap, abort, reset.
module tb_count_sched;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 4;

   logic              clock;
   logic              reset;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] len;
   logic              tick;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic [W-1:0]      count_out;

   int n_tests;
   int n_fail;

   count_sched #(.NREQ(NREQ), .W(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .len       (len),
      .tick      (tick),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .count_out (count_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      req     = '0;
      len     = '0;
      tick    = 1'b0;
      step();
      step();
      chk("rst_gnt",   32'(gnt), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_count", 32'(count_out), 32'h0);

      // Single job on requester 0, len 3
      reset = 1'b0;
      len   = 16'h0003;
      tick  = 1'b1;
      req   = 4'b0001;
      step();
      chk("t1_gnt",   32'(gnt), 32'h1);
      chk("t1_busy",  32'(busy), 32'h1);
      chk("t1_cnt0",  32'(count_out), 32'h0);
      step();
      chk("t1_cnt1",  32'(count_out), 32'h1);
      step();
      chk("t1_cnt2",  32'(count_out), 32'h2);
      chk("t1_nodone", 32'(done), 32'h0);
      step();
      chk("t1_done",  32'(done), 32'h1);
      chk("t1_gnt_clr", 32'(gnt), 32'h0);
      req = 4'b0000;
      step();
      chk("t1_done_1cyc", 32'(done), 32'h0);
      chk("t1_busy_lo", 32'(busy), 32'h0);
      chk("t1_hold",  32'(count_out), 32'h3);

      // Round-robin from reset: 0,1,2,3,0 with one idle cycle between
      reset = 1'b1;
      step();
      reset = 1'b0;
      len   = 16'h1111;
      req   = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
         step();
         chk("rr_done", 32'(done), 32'(1) << (k % 4));
         chk("rr_gnt_off", 32'(gnt), 32'h0);
         if (k == 4) req = 4'b0000;
         step();
         chk("rr_idle_gnt", 32'(gnt), 32'h0);
         chk("rr_idle_busy", 32'(busy), 32'h0);
      end

      // Sparse tick on requester 2, len 2
      len  = 16'h0200;
      req  = 4'b0100;
      tick = 1'b0;
      step();
      chk("sp_gnt", 32'(gnt), 32'h4);
      chk("sp_cnt0", 32'(count_out), 32'h0);
      for (int c = 0; c < 6; c++) begin
         tick = (c % 3 == 2);
         step();
         chk("sp_cnt", 32'(count_out), 32'((c + 1) / 3));
         chk("sp_done", 32'(done), (c == 5) ? 32'h4 : 32'h0);
      end
      tick = 1'b0;
      req  = 4'b0000;
      step();
      chk("sp_idle_done", 32'(done), 32'h0);
      chk("sp_idle_busy", 32'(busy), 32'h0);
      chk("sp_hold", 32'(count_out), 32'h2);

      // len 0 on requester 1 means a full 16-tick wrap
      len  = 16'h0000;
      req  = 4'b0010;
      tick = 1'b1;
      step();
      chk("wr_gnt", 32'(gnt), 32'h2);
      chk("wr_cnt0", 32'(count_out), 32'h0);
      for (int t = 1; t <= 16; t++) begin
         step();
         chk("wr_cnt", 32'(count_out), 32'(t % 16));
         chk("wr_done", 32'(done), (t == 16) ? 32'h2 : 32'h0);
         chk("wr_gnt_t", 32'(gnt), (t == 16) ? 32'h0 : 32'h2);
      end
      req = 4'b0000;
      step();
      chk("wr_busy_lo", 32'(busy), 32'h0);

      // Abort requester 3 at count 1; next grant goes to requester 0
      len  = 16'h5000;
      req  = 4'b1000;
      tick = 1'b1;
      step();
      chk("ab_gnt", 32'(gnt), 32'h8);
      step();
      chk("ab_cnt1", 32'(count_out), 32'h1);
      req = 4'b0111;
      len = 16'h5001;
      step();
      chk("ab_gnt_clr", 32'(gnt), 32'h0);
      chk("ab_nodone", 32'(done), 32'h0);
      chk("ab_busy_lo", 32'(busy), 32'h0);
      step();
      chk("ab_next_gnt", 32'(gnt), 32'h1);
      chk("ab_next_cnt", 32'(count_out), 32'h0);
      // Abort coincides with terminal count: abort wins
      req = 4'b0000;
      step();
      chk("ab_prio_done", 32'(done), 32'h0);
      chk("ab_prio_gnt", 32'(gnt), 32'h0);
      chk("ab_prio_busy", 32'(busy), 32'h0);

      // Reset during COUNT at count 2
      len  = 16'h0005;
      req  = 4'b0001;
      tick = 1'b1;
      step();
      chk("rs_gnt", 32'(gnt), 32'h1);
      step();
      step();
      chk("rs_cnt2", 32'(count_out), 32'h2);
      reset = 1'b1;
      step();
      chk("rs_gnt_clr", 32'(gnt), 32'h0);
      chk("rs_done", 32'(done), 32'h0);
      chk("rs_busy", 32'(busy), 32'h0);
      chk("rs_cnt", 32'(count_out), 32'h0);
      reset = 1'b0;
      step();
      chk("rs_regnt", 32'(gnt), 32'h1);
      chk("rs_regnt_busy", 32'(busy), 32'h1);
      chk("rs_regnt_cnt", 32'(count_out), 32'h0);
      req = 4'b0000;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
